mant_mult_norm: RTL and testbench
=================================

MANT_MULT_NORM -- requirements
Module: mant_mult_norm

Interface
REQ-001 Parameter BITS_PER_CYCLE, default 1, multiplier bits retired per iteration; legal values 1,2,3,4,6,8,12; N = 24/BITS_PER_CYCLE iterations.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 a_mant  input  24  operand A significand, hidden bit included.
REQ-005 b_mant  input  24  operand B significand, hidden bit included.
REQ-006 a_sign, b_sign  input  1 each  operand signs.
REQ-007 in_valid  input  1  operands valid; in_ready  output  1  block can accept operands.
REQ-008 mantissa_round_input  output  24  normalized product significand, consumed by the rounding stage.
REQ-009 pipe_guard  output  1  first bit below the kept 24; pipe_sticky  output  1  OR of all lower bits.
REQ-010 pipe_sign  output  1  a_sign XOR b_sign.
REQ-011 norm_shift  output  1  1 when the product was in [2,4) and was shifted right one place (exponent +1 downstream).
REQ-012 out_valid  output  1  result valid; out_ready  input  1  downstream accepts.

Function
REQ-013 FSM states IDLE, MULT, NORM, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid=1, capture a_mant, b_mant and sign XOR, clear the 48-bit accumulator and iteration counter, go to MULT.
REQ-015 MULT: each cycle add (a_mant x next BITS_PER_CYCLE bits of b_mant, LSB first) at the correct weight into the 48-bit accumulator; after iteration N go to NORM.
REQ-016 Accumulator arithmetic SHALL be exact; full product P[47:0] = a_mant x b_mant, no truncation before NORM.
REQ-017 NORM (one cycle): if P[47]=1 -> mantissa=P[47:24], guard=P[23], sticky=|P[22:0], norm_shift=1; else mantissa=P[46:23], guard=P[22], sticky=|P[21:0], norm_shift=0; register the outputs and go to DONE.
REQ-018 Zero operand: P=0 yields mantissa=0, guard=0, sticky=0, norm_shift=0; pipe_sign is still the XOR of the signs.
REQ-019 Latency: out_valid SHALL rise exactly N+1 rising edges after the in_valid/in_ready handshake edge (25 edges for BITS_PER_CYCLE=1).
REQ-020 DONE: all outputs SHALL be held stable while out_valid=1 and out_ready=0; on out_ready=1, go to IDLE (in_ready=1 the next cycle).
REQ-021 No overlap: a new operand pair SHALL NOT be accepted in the same cycle as the output handshake.
REQ-022 Inputs a_mant, b_mant, a_sign, b_sign and in_valid SHALL be ignored outside IDLE.
REQ-023 out_ready SHALL be ignored outside DONE.

Reset
REQ-024 rst=0 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, and clear all result outputs, accumulator and counter; this has priority over every other event.
REQ-025 Reset asserted during MULT, NORM or DONE SHALL abort the operation with no partial result ever presented.

Verification
REQ-026 a=b=0x800000, signs 0/0 -> after 25 edges: mantissa=0x800000, guard=0, sticky=0, norm_shift=0, sign=0.
REQ-027 a=b=0xFFFFFF -> mantissa=0xFFFFFE, guard=0, sticky=1, norm_shift=1.
REQ-028 a=0x800001, b=0xC00000, a_sign=1, b_sign=0 -> mantissa=0xC00001, guard=1, sticky=0, norm_shift=0, sign=1 (tie case).
REQ-029 a=b=0xC00000 -> mantissa=0x900000, guard=0, sticky=0, norm_shift=1; a=0, b=0xABCDEF -> all zero.
REQ-030 out_ready=0 for 10 cycles in DONE -> outputs constant, in_ready=0, and an in_valid pulse during DONE is ignored; out_ready=1 -> IDLE next cycle.
REQ-031 rst=0 at iteration 10 of MULT -> next edge: out_valid=0, in_ready=1, outputs 0; a following operation gives the correct result; repeat all of the above with BITS_PER_CYCLE=4 (latency 7 edges).

Source files
------------

// File: rtl/mant_mult_norm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mant_mult_norm                                                             |
// | Iterative 24x24 significand multiplier with single-cycle normalization.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mant_mult_norm #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] a_mant,
  input  logic [23:0] b_mant,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] mantissa_round_input,
  output logic        pipe_guard,
  output logic        pipe_sticky,
  output logic        pipe_sign,
  output logic        norm_shift,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int         c_iters = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] c_last  = 5'(c_iters - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_mult = 2'd1;
  localparam logic [1:0] c_norm = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]  r_state;
  logic [47:0] r_acc;
  logic [47:0] r_a_sh;
  logic [23:0] r_b_sh;
  logic [4:0]  r_cnt;
  logic        r_sign;

  logic [23:0] r_mant;
  logic        r_guard;
  logic        r_sticky;
  logic        r_sign_out;
  logic        r_norm_shift;

  logic [47:0] w_term [BITS_PER_CYCLE];
  logic [47:0] w_sum;
  logic [23:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_shift;

  // A is pre-shifted to the weight of the current multiplier chunk, so each
  // partial product only needs the small intra-chunk offset gi.
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign w_term[gi] = r_b_sh[gi] ? (r_a_sh << gi) : 48'd0;
    end
  endgenerate

  always_comb begin
    w_sum = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_sum = w_sum + w_term[i];
    end
  end

  // Product of two [1,2) significands lies in [1,4); bit 47 selects the range.
  always_comb begin
    w_mant   = 24'd0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_shift  = 1'b0;
    if (r_acc[47]) begin
      w_mant   = r_acc[47:24];
      w_guard  = r_acc[23];
      w_sticky = |r_acc[22:0];
      w_shift  = 1'b1;
    end else begin
      w_mant   = r_acc[46:23];
      w_guard  = r_acc[22];
      w_sticky = |r_acc[21:0];
      w_shift  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= c_idle;
      r_acc        <= 48'd0;
      r_a_sh       <= 48'd0;
      r_b_sh       <= 24'd0;
      r_cnt        <= 5'd0;
      r_sign       <= 1'b0;
      r_mant       <= 24'd0;
      r_guard      <= 1'b0;
      r_sticky     <= 1'b0;
      r_sign_out   <= 1'b0;
      r_norm_shift <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_a_sh  <= {24'd0, a_mant};
            r_b_sh  <= b_mant;
            r_sign  <= a_sign ^ b_sign;
            r_acc   <= 48'd0;
            r_cnt   <= 5'd0;
            r_state <= c_mult;
          end
        end
        c_mult: begin
          r_acc  <= w_sum;
          r_a_sh <= r_a_sh << BITS_PER_CYCLE;
          r_b_sh <= r_b_sh >> BITS_PER_CYCLE;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == c_last) begin
            r_state <= c_norm;
          end
        end
        c_norm: begin
          r_mant       <= w_mant;
          r_guard      <= w_guard;
          r_sticky     <= w_sticky;
          r_norm_shift <= w_shift;
          r_sign_out   <= r_sign;
          r_state      <= c_done;
        end
        c_done: begin
          if (out_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready             = (r_state == c_idle);
  assign out_valid            = (r_state == c_done);
  assign mantissa_round_input = r_mant;
  assign pipe_guard           = r_guard;
  assign pipe_sticky          = r_sticky;
  assign pipe_sign            = r_sign_out;
  assign norm_shift           = r_norm_shift;

endmodule
`default_nettype wire

// File: tb/tb_mant_mult_norm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mant_mult_norm                                                          |
// | Self-checking bench running BITS_PER_CYCLE=1 and =4 instances side by side.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mant_mult_norm;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        sa;
    logic        sb;
    logic [23:0] m;
    logic        g;
    logic        s;
    logic        ns;
    logic        sg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] a_mant, b_mant;
  logic        a_sign, b_sign, in_valid, out_ready;

  logic        in_ready1, out_valid1, guard1, sticky1, sign1, ns1;
  logic [23:0] mant1;
  logic        in_ready4, out_valid4, guard4, sticky4, sign4, ns4;
  logic [23:0] mant4;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t q1[$];
  vec_t q4[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  mant_mult_norm #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .a_mant(a_mant), .b_mant(b_mant),
    .a_sign(a_sign), .b_sign(b_sign), .in_valid(in_valid), .in_ready(in_ready1),
    .mantissa_round_input(mant1), .pipe_guard(guard1), .pipe_sticky(sticky1),
    .pipe_sign(sign1), .norm_shift(ns1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  mant_mult_norm #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .a_mant(a_mant), .b_mant(b_mant),
    .a_sign(a_sign), .b_sign(b_sign), .in_valid(in_valid), .in_ready(in_ready4),
    .mantissa_round_input(mant4), .pipe_guard(guard4), .pipe_sticky(sticky4),
    .pipe_sign(sign4), .norm_shift(ns4), .out_valid(out_valid4), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b, input logic sa,
                              input logic sb, input logic [23:0] m, input logic g,
                              input logic s, input logic ns, input logic sg);
    vec_t v;
    v.a = a; v.b = b; v.sa = sa; v.sb = sb;
    v.m = m; v.g = g; v.s = s; v.ns = ns; v.sg = sg;
    return v;
  endfunction

  // Reference: full-width product, then pick the 24-bit window by range.
  function automatic vec_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic sa, input logic sb);
    logic [47:0] p;
    vec_t        v;
    p = 48'(a) * 48'(b);
    v = mk(a, b, sa, sb, 24'd0, 1'b0, 1'b0, 1'b0, sa ^ sb);
    if (p[47]) begin
      v.m = p[47:24]; v.g = p[23]; v.s = |p[22:0]; v.ns = 1'b1;
    end else begin
      v.m = p[46:23]; v.g = p[22]; v.s = |p[21:0]; v.ns = 1'b0;
    end
    return v;
  endfunction

  task automatic chk_res(input string tag, input vec_t e, input logic [23:0] m,
                         input logic g, input logic s, input logic ns, input logic sg);
    chk({tag, "_mant"},   32'(m),  32'(e.m));
    chk({tag, "_guard"},  32'(g),  32'(e.g));
    chk({tag, "_sticky"}, 32'(s),  32'(e.s));
    chk({tag, "_shift"},  32'(ns), 32'(e.ns));
    chk({tag, "_sign"},   32'(sg), 32'(e.sg));
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    chk("in_ready1_before_op", 32'(in_ready1), 32'd1);
    chk("in_ready4_before_op", 32'(in_ready4), 32'd1);
    a_mant = v.a; b_mant = v.b; a_sign = v.sa; b_sign = v.sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   lat1, lat4;
    bit   seen1, seen4;
    vec_t e;
    lat1 = 0; lat4 = 0; seen1 = 1'b0; seen4 = 1'b0;
    q1.push_back(v);
    q4.push_back(v);
    start_op(v);
    for (int k = 1; k <= 60 && !(seen1 && seen4); k++) begin
      @(posedge clk);
      #1;
      if (!seen1 && out_valid1) begin seen1 = 1'b1; lat1 = k; end
      if (!seen4 && out_valid4) begin seen4 = 1'b1; lat4 = k; end
    end
    chk({tag, "_latency_bpc1"}, 32'(lat1), 32'd25);
    chk({tag, "_latency_bpc4"}, 32'(lat4), 32'd7);
    if (q1.size() == 0 || q4.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = q1.pop_front();
      chk_res({tag, "_bpc1"}, e, mant1, guard1, sticky1, ns1, sign1);
      e = q4.pop_front();
      chk_res({tag, "_bpc4"}, e, mant4, guard4, sticky4, ns4, sign4);
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_in_ready1_after_release"},  32'(in_ready1),  32'd1);
    chk({tag, "_in_ready4_after_release"},  32'(in_ready4),  32'd1);
    chk({tag, "_out_valid1_after_release"}, 32'(out_valid1), 32'd0);
    chk({tag, "_out_valid4_after_release"}, 32'(out_valid4), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t hold_e;
    tbl[0] = mk(24'h800000, 24'h800000, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[2] = mk(24'h800001, 24'hC00000, 1'b1, 1'b0, 24'hC00001, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(24'hC00000, 24'hC00000, 1'b1, 1'b1, 24'h900000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(24'h000000, 24'hABCDEF, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 6; i < 10; i++) begin
      tbl[i] = model(24'($urandom) | 24'h800000, 24'($urandom) | 24'h800000,
                     1'($urandom), 1'($urandom));
    end

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_mant = 24'd0; b_mant = 24'd0; a_sign = 1'b0; b_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready1",  32'(in_ready1),  32'd1);
    chk("reset_out_valid1", 32'(out_valid1), 32'd0);
    chk("reset_mant1",      32'(mant1),      32'd0);
    chk("reset_in_ready4",  32'(in_ready4),  32'd1);
    chk("reset_out_valid4", 32'(out_valid4), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end

    // Stall in DONE; an in_valid pulse with new operands must not be taken.
    hold_e = tbl[1];
    run_op(hold_e, "hold");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        a_mant = 24'h123456; b_mant = 24'h654321; a_sign = 1'b1; b_sign = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_valid1", k), 32'(out_valid1), 32'd1);
      chk($sformatf("hold%0d_ready1", k), 32'(in_ready1),  32'd0);
      chk($sformatf("hold%0d_ready4", k), 32'(in_ready4),  32'd0);
      chk_res($sformatf("hold%0d_bpc1", k), hold_e, mant1, guard1, sticky1, ns1, sign1);
      chk_res($sformatf("hold%0d_bpc4", k), hold_e, mant4, guard4, sticky4, ns4, sign4);
    end
    in_valid = 1'b0;
    release_out("hold");

    run_op(tbl[3], "after_hold");
    release_out("after_hold");

    // Reset lands at MULT iteration 10 for BPC=1 and during DONE for BPC=4.
    start_op(tbl[2]);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid1", 32'(out_valid1), 32'd0);
    chk("abort_in_ready1",  32'(in_ready1),  32'd1);
    chk("abort_out_valid4", 32'(out_valid4), 32'd0);
    chk("abort_in_ready4",  32'(in_ready4),  32'd1);
    chk_res("abort_bpc1", mk(24'd0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0),
            mant1, guard1, sticky1, ns1, sign1);
    chk_res("abort_bpc4", mk(24'd0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0),
            mant4, guard4, sticky4, ns4, sign4);
    @(negedge clk);
    rst = 1'b1;

    run_op(tbl[1], "after_abort");
    release_out("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
